// File: rtl/bpu_gshare.sv
// Fetch-stage branch predictor: direct-mapped BTB, gshare PHT and speculative RAS
// over a two-slot fetch window (pc, pc+4), restored from execute snapshots on redirect.
module bpu_gshare #(
   parameter int COUNTER_BITS = 2,
   parameter int BTB_ENTRIES  = 64,
   parameter int TAG_BITS     = 10,
   parameter int PHT_ENTRIES  = 1024,
   parameter int GHR_BITS     = 8,
   parameter int RAS_DEPTH    = 8
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic [31:0]                  f1_pc,
   input  logic                         f1_advance,
   output logic                         f1_taken,
   output logic                         f1_pos,
   output logic [31:0]                  f1_pre_pc,
   output logic [GHR_BITS-1:0]          f1_ghr,
   output logic [$clog2(RAS_DEPTH)-1:0] f1_ras_ptr,
   input  logic                         ex_valid,
   input  logic [31:0]                  ex_pc,
   input  logic [1:0]                   ex_type,
   input  logic                         ex_taken,
   input  logic [31:0]                  ex_dest,
   input  logic [GHR_BITS-1:0]          ex_ghr,
   input  logic [$clog2(RAS_DEPTH)-1:0] ex_ras_ptr,
   input  logic                         ex_redirect
);

   localparam int BI = $clog2(BTB_ENTRIES);
   localparam int PI = $clog2(PHT_ENTRIES);
   localparam int RI = $clog2(RAS_DEPTH);
   localparam int CI = RI + 1;

   localparam logic [1:0] T_BR   = 2'd0;
   localparam logic [1:0] T_J    = 2'd1;
   localparam logic [1:0] T_CALL = 2'd2;
   localparam logic [1:0] T_RET  = 2'd3;

   localparam logic [COUNTER_BITS-1:0] CTR_MAX  = '1;
   localparam logic [COUNTER_BITS-1:0] CTR_INIT = {1'b0, {(COUNTER_BITS-1){1'b1}}};
   localparam logic [CI-1:0]           CNT_MAX  = CI'(RAS_DEPTH);

   logic                    btb_v   [BTB_ENTRIES];
   logic [TAG_BITS-1:0]     btb_tag [BTB_ENTRIES];
   logic [1:0]              btb_typ [BTB_ENTRIES];
   logic [31:0]             btb_tgt [BTB_ENTRIES];
   logic [COUNTER_BITS-1:0] pht     [PHT_ENTRIES];
   logic [31:0]             ras     [RAS_DEPTH];

   logic [GHR_BITS-1:0]     ghr;
   logic [RI-1:0]           ras_ptr;
   logic [CI-1:0]           ras_cnt;

   logic [31:0]             slot_pc  [2];
   logic [31:0]             slot_tgt [2];
   logic [1:0]              slot_typ [2];
   logic                    slot_hit [2];
   logic                    slot_tk  [2];
   logic [BI-1:0]           bidx     [2];
   logic [PI-1:0]           pidx     [2];

   logic [31:0]             ras_top;
   logic                    sel;
   logic [1:0]              ch_typ;
   logic [31:0]             ch_pc;
   logic                    br_seen;
   logic                    spec_push;
   logic                    spec_pop;

   logic                    ras_we;
   logic [RI-1:0]           ras_wa;
   logic [31:0]             ras_wd;

   logic [BI-1:0]           ex_bidx;
   logic [PI-1:0]           ex_pidx;

   assign ex_bidx = ex_pc[BI+1:2];
   assign ex_pidx = ex_pc[PI+1:2] ^ PI'(ex_ghr);

   always_comb begin
      ras_top = ras[ras_ptr - RI'(1)];
      for (int s = 0; s < 2; s++) begin
         slot_pc[s]  = f1_pc + 32'(4 * s);
         bidx[s]     = slot_pc[s][BI+1:2];
         pidx[s]     = slot_pc[s][PI+1:2] ^ PI'(ghr);
         slot_hit[s] = btb_v[bidx[s]] && (btb_tag[bidx[s]] == slot_pc[s][BI+2 +: TAG_BITS]);
         slot_typ[s] = btb_typ[bidx[s]];
         slot_tgt[s] = btb_tgt[bidx[s]];
         slot_tk[s]  = 1'b0;
         if (slot_hit[s]) begin
            case (slot_typ[s])
               T_BR:    slot_tk[s] = pht[pidx[s]][COUNTER_BITS-1];
               T_J,
               T_CALL:  slot_tk[s] = 1'b1;
               default: begin
                  slot_tk[s] = 1'b1;
                  if (ras_cnt != '0) slot_tgt[s] = ras_top;
               end
            endcase
         end
      end
   end

   // Slot 0 wins; slot 1 is only consumed when slot 0 does not redirect.
   always_comb begin
      sel        = !slot_tk[0];
      f1_taken   = slot_tk[0] | slot_tk[1];
      f1_pos     = slot_tk[0];
      f1_pre_pc  = f1_taken ? slot_tgt[sel] : 32'h0;
      f1_ghr     = ghr;
      f1_ras_ptr = ras_ptr;
      ch_typ     = slot_typ[sel];
      ch_pc      = slot_pc[sel];
      br_seen    = (slot_hit[0] && slot_typ[0] == T_BR) ||
                   (!slot_tk[0] && slot_hit[1] && slot_typ[1] == T_BR);
      spec_push  = f1_taken && ch_typ == T_CALL;
      spec_pop   = f1_taken && ch_typ == T_RET && ras_cnt != '0;
   end

   always_comb begin
      ras_we = 1'b0;
      ras_wa = ras_ptr;
      ras_wd = ch_pc + 32'd8;
      if (ex_redirect) begin
         if (ex_type == T_CALL) begin
            ras_we = 1'b1;
            ras_wa = ex_ras_ptr;
            ras_wd = ex_pc + 32'd8;
         end
      end else if (f1_advance && spec_push) begin
         ras_we = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < BTB_ENTRIES; i++) btb_v[i] <= 1'b0;
         for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= CTR_INIT;
         ghr     <= '0;
         ras_ptr <= '0;
         ras_cnt <= '0;
      end else begin
         if (ex_valid && ex_type == T_BR) begin
            if (ex_taken && pht[ex_pidx] != CTR_MAX)
               pht[ex_pidx] <= pht[ex_pidx] + 1'b1;
            else if (!ex_taken && pht[ex_pidx] != '0)
               pht[ex_pidx] <= pht[ex_pidx] - 1'b1;
         end
         if (ex_valid && ex_taken) btb_v[ex_bidx] <= 1'b1;

         if (ex_redirect) begin
            ghr <= (ex_type == T_BR) ? {ex_ghr[GHR_BITS-2:0], ex_taken} : ex_ghr;
            case (ex_type)
               T_CALL: begin
                  ras_ptr <= ex_ras_ptr + RI'(1);
                  if (ras_cnt != CNT_MAX) ras_cnt <= ras_cnt + 1'b1;
               end
               T_RET: begin
                  ras_ptr <= ex_ras_ptr - RI'(1);
                  if (ras_cnt != '0) ras_cnt <= ras_cnt - 1'b1;
               end
               default: ras_ptr <= ex_ras_ptr;
            endcase
         end else if (f1_advance) begin
            if (br_seen) ghr <= {ghr[GHR_BITS-2:0], f1_taken && ch_typ == T_BR};
            if (spec_push) begin
               ras_ptr <= ras_ptr + RI'(1);
               if (ras_cnt != CNT_MAX) ras_cnt <= ras_cnt + 1'b1;
            end else if (spec_pop) begin
               ras_ptr <= ras_ptr - RI'(1);
               ras_cnt <= ras_cnt - 1'b1;
            end
         end
      end
   end

   // Payload arrays carry no reset; btb_v and ras_cnt qualify them.
   always_ff @(posedge clk) begin
      if (ex_valid && ex_taken) begin
         btb_tag[ex_bidx] <= ex_pc[BI+2 +: TAG_BITS];
         btb_typ[ex_bidx] <= ex_type;
         btb_tgt[ex_bidx] <= ex_dest;
      end
      if (ras_we) ras[ras_wa] <= ras_wd;
   end

endmodule

// File: tb/tb_bpu_gshare.sv
// Self-checking bench for bpu_gshare: directed scenarios plus random traffic
// compared against a table/queue reference model of the predictor.
module tb_bpu_gshare;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] f1_pc;
   logic        f1_advance;
   logic        f1_taken;
   logic        f1_pos;
   logic [31:0] f1_pre_pc;
   logic [7:0]  f1_ghr;
   logic [2:0]  f1_ras_ptr;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [1:0]  ex_type;
   logic        ex_taken;
   logic [31:0] ex_dest;
   logic [7:0]  ex_ghr;
   logic [2:0]  ex_ras_ptr;
   logic        ex_redirect;

   always #5 clk = ~clk;

   bpu_gshare dut (
      .clk(clk), .resetn(resetn),
      .f1_pc(f1_pc), .f1_advance(f1_advance),
      .f1_taken(f1_taken), .f1_pos(f1_pos), .f1_pre_pc(f1_pre_pc),
      .f1_ghr(f1_ghr), .f1_ras_ptr(f1_ras_ptr),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_type(ex_type), .ex_taken(ex_taken),
      .ex_dest(ex_dest), .ex_ghr(ex_ghr), .ex_ras_ptr(ex_ras_ptr),
      .ex_redirect(ex_redirect)
   );

   int nchecks = 0;
   int nerrors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchecks++;
      if (obs !== exp) begin
         nerrors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // reference model state
   bit          m_v   [64];
   int unsigned m_tag [64];
   int unsigned m_typ [64];
   logic [31:0] m_tgt [64];
   int          m_pht [1024];
   int unsigned m_ghr;
   logic [31:0] m_ras [$];
   int unsigned m_ptr;

   task automatic model_reset();
      for (int i = 0; i < 64; i++) m_v[i] = 1'b0;
      for (int i = 0; i < 1024; i++) m_pht[i] = 1;
      m_ghr = 0;
      m_ptr = 0;
      m_ras.delete();
   endtask

   task automatic predict(input logic [31:0] pc, output bit tk, output bit pos,
                          output logic [31:0] tgt, output bit br_seen,
                          output int unsigned ch_typ, output logic [31:0] ch_pc);
      bit          stk [2];
      bit          sbr [2];
      logic [31:0] st  [2];
      int unsigned sty [2];
      logic [31:0] sp  [2];
      for (int s = 0; s < 2; s++) begin
         int unsigned i;
         bit hit;
         sp[s]  = pc + 32'(4 * s);
         i      = (sp[s] >> 2) % 64;
         hit    = m_v[i] && m_tag[i] == (sp[s] >> 8) % 1024;
         sty[s] = m_typ[i];
         st[s]  = m_tgt[i];
         stk[s] = 1'b0;
         sbr[s] = hit && sty[s] == 0;
         if (hit) begin
            if (sty[s] == 0) stk[s] = m_pht[((sp[s] >> 2) % 1024) ^ m_ghr] >= 2;
            else stk[s] = 1'b1;
            if (sty[s] == 3 && m_ras.size() > 0) st[s] = m_ras[$];
         end
      end
      if (stk[0]) begin
         tk = 1; pos = 1; tgt = st[0]; ch_typ = sty[0]; ch_pc = sp[0];
      end else if (stk[1]) begin
         tk = 1; pos = 0; tgt = st[1]; ch_typ = sty[1]; ch_pc = sp[1];
      end else begin
         tk = 0; pos = 0; tgt = 0; ch_typ = 0; ch_pc = 0;
      end
      br_seen = sbr[0] || (!stk[0] && sbr[1]);
   endtask

   // One cycle: drive at negedge, compare at negedge+1, advance the model across the posedge.
   task automatic step(input logic [31:0] pc, input bit adv, input bit exv,
                       input logic [1:0] et, input bit etk, input logic [31:0] epc,
                       input logic [31:0] edst, input bit ered, input int unsigned eg);
      bit          tk, pos, brs;
      logic [31:0] tgt, cpc;
      int unsigned ctyp;
      @(negedge clk);
      f1_pc = pc; f1_advance = adv;
      ex_valid = exv; ex_type = et; ex_taken = etk; ex_pc = epc; ex_dest = edst;
      ex_redirect = ered; ex_ghr = 8'(eg); ex_ras_ptr = 3'(m_ptr);
      #1;
      predict(pc, tk, pos, tgt, brs, ctyp, cpc);
      check("f1_taken", {31'b0, f1_taken}, {31'b0, tk});
      check("f1_pos", {31'b0, f1_pos}, {31'b0, pos});
      check("f1_pre_pc", f1_pre_pc, tgt);
      check("f1_ghr", {24'b0, f1_ghr}, m_ghr);
      check("f1_ras_ptr", {29'b0, f1_ras_ptr}, m_ptr);
      if (exv && et == 0) begin
         int unsigned pi;
         pi = ((epc >> 2) % 1024) ^ (eg % 256);
         if (etk && m_pht[pi] < 3) m_pht[pi]++;
         else if (!etk && m_pht[pi] > 0) m_pht[pi]--;
      end
      if (exv && etk) begin
         int unsigned bi;
         bi = (epc >> 2) % 64;
         m_v[bi] = 1; m_tag[bi] = (epc >> 8) % 1024; m_typ[bi] = et; m_tgt[bi] = edst;
      end
      if (ered) begin
         m_ghr = (et == 0) ? ((eg << 1) | etk) % 256 : eg % 256;
      end else if (adv) begin
         if (brs) m_ghr = ((m_ghr << 1) | (tk && ctyp == 0)) % 256;
         if (tk && ctyp == 2) begin
            m_ras.push_back(cpc + 8);
            if (m_ras.size() > 8) void'(m_ras.pop_front());
            m_ptr = (m_ptr + 1) % 8;
         end else if (tk && ctyp == 3 && m_ras.size() > 0) begin
            void'(m_ras.pop_back());
            m_ptr = (m_ptr + 7) % 8;
         end
      end
   endtask

   task automatic idle(input logic [31:0] pc, input bit adv);
      step(pc, adv, 0, 2'd0, 0, 32'h0, 32'h0, 0, 0);
   endtask

   task automatic train(input logic [1:0] et, input bit etk, input logic [31:0] epc,
                        input logic [31:0] edst);
      step(32'h0, 0, 1, et, etk, epc, edst, 0, 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_taken"}, {31'b0, f1_taken}, 32'h0);
      check({tag, "_pos"}, {31'b0, f1_pos}, 32'h0);
      check({tag, "_pre_pc"}, f1_pre_pc, 32'h0);
      check({tag, "_ghr"}, {24'b0, f1_ghr}, 32'h0);
      check({tag, "_ras_ptr"}, {29'b0, f1_ras_ptr}, 32'h0);
   endtask

   initial begin
      resetn = 0; f1_pc = 32'h1000; f1_advance = 0;
      ex_valid = 0; ex_pc = 0; ex_type = 0; ex_taken = 0; ex_dest = 0;
      ex_ghr = 0; ex_ras_ptr = 0; ex_redirect = 0;
      model_reset();
      #12;
      check_all_zero("reset");
      @(negedge clk);
      resetn = 1;

      idle(32'h1000, 0);
      check("cold_taken", {31'b0, f1_taken}, 32'h0);
      check("cold_pre_pc", f1_pre_pc, 32'h0);

      repeat (3) train(2'd0, 1, 32'h1004, 32'h2000);
      idle(32'h1000, 0);
      check("br_slot1_taken", {31'b0, f1_taken}, 32'h1);
      check("br_slot1_pos", {31'b0, f1_pos}, 32'h0);
      check("br_slot1_pre_pc", f1_pre_pc, 32'h2000);

      train(2'd2, 1, 32'h3000, 32'h5000);
      idle(32'h3000, 1);
      check("call_pre_pc", f1_pre_pc, 32'h5000);
      check("call_pos", {31'b0, f1_pos}, 32'h1);
      train(2'd3, 1, 32'h5010, 32'h7770);
      idle(32'h5010, 1);
      check("ret_pre_pc", f1_pre_pc, 32'h3008);
      idle(32'h0, 0);
      check("ret_ptr_back", {29'b0, f1_ras_ptr}, 32'h0);

      for (int i = 0; i < 9; i++) train(2'd2, 1, 32'h8010 + 32'(16 * i), 32'hA000);
      train(2'd3, 1, 32'hA000, 32'hBEE0);
      for (int i = 0; i < 9; i++) idle(32'h8010 + 32'(16 * i), 1);
      for (int k = 0; k < 9; k++) begin
         idle(32'hA000, 1);
         check("ras_lifo", f1_pre_pc, (k < 8) ? 32'h8018 + 32'(16 * (8 - k)) : 32'hBEE0);
      end

      idle(32'h1004, 1);
      step(32'h1004, 1, 1, 2'd0, 0, 32'h1004, 32'h1004, 1, 0);
      check("ghr_spec", {24'b0, f1_ghr}, 32'h01);
      idle(32'h0, 0);
      check("ghr_restored", {24'b0, f1_ghr}, 32'h00);

      repeat (5) train(2'd0, 1, 32'h2200, 32'h2400);
      train(2'd0, 0, 32'h2200, 32'h2400);
      idle(32'h2200, 0);
      check("sat_still_taken", {31'b0, f1_taken}, 32'h1);
      check("sat_pre_pc", f1_pre_pc, 32'h2400);
      train(2'd0, 0, 32'h2200, 32'h2400);
      idle(32'h2200, 0);
      check("sat_now_not_taken", {31'b0, f1_taken}, 32'h0);

      repeat (2) train(2'd0, 1, 32'h2200, 32'h2400);
      idle(32'h2200, 0);
      #2 resetn = 0;
      #1 check_all_zero("mid_reset");
      model_reset();
      @(negedge clk);
      @(negedge clk);
      resetn = 1;

      for (int n = 0; n < 600; n++) begin
         logic [1:0]  et;
         bit          exv, etk, ered;
         et   = 2'($urandom_range(0, 3));
         exv  = 1'($urandom_range(0, 1));
         etk  = (et == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
         ered = exv && et <= 1 && $urandom_range(0, 7) == 0;
         step(32'h4000 + 32'(4 * $urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              exv, et, etk, 32'h4000 + 32'(4 * $urandom_range(0, 15)),
              $urandom() & 32'hFFFF_FFFC, ered, $urandom_range(0, 255));
      end

      $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
      $finish;
   end

endmodule

// File: doc/bpu_gshare.md
Name: bpu_gshare

Overview:
- Next-generation fetch-stage branch predictor with a unified direct-mapped BTB, a gshare PHT of saturating counters, and a speculative return-address stack (RAS).
- Predicts over a two-slot fetch window (pc, pc+4). It updates history and the RAS speculatively at fetch, and restores them from execute-stage snapshots on redirect.
- Sits between the F1 PC mux and the execute-stage branch resolution unit.

Parameters:
COUNTER_BITS, 2, PHT counter width (>=2)
BTB_ENTRIES, 64, BTB entries, power of 2
TAG_BITS, 10, BTB tag width
PHT_ENTRIES, 1024, PHT counters, power of 2
GHR_BITS, 8, global history length, <= log2(PHT_ENTRIES)
RAS_DEPTH, 8, RAS entries, power of 2

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
f1_pc  in  32  fetch PC (word aligned)
f1_advance  in  1  F1 accepted this cycle; commit speculative GHR/RAS update
f1_taken  out  1  predicted redirect
f1_pos  out  1  1 = predicting instruction is at f1_pc; 0 = at f1_pc+4
f1_pre_pc  out  32  predicted target, 0 when !f1_taken
f1_ghr  out  GHR_BITS  history before this fetch (snapshot, travels with instruction)
f1_ras_ptr  out  log2(RAS_DEPTH)  RAS top pointer before this fetch (snapshot)
ex_valid  in  1  resolved control instruction
ex_pc  in  32  its PC
ex_type  in  2  0 BR, 1 J/JAL-to-imm, 2 CALL (jal/jalr), 3 RET (jr ra)
ex_taken  in  1  actual direction (1 for types 1-3)
ex_dest  in  32  actual target
ex_ghr  in  GHR_BITS  snapshot carried from F1
ex_ras_ptr  in  log2(RAS_DEPTH)  snapshot carried from F1
ex_redirect  in  1  mispredict; restore speculative state

Behaviour:
Lookup (combinational from registered state; same-cycle writes not visible):
- Slot s PC p = f1_pc + 4s.
- BTB index = p[log2(BTB_ENTRIES)+1:2]; tag = next TAG_BITS bits above the index.
- Entry = valid, tag, type, target. Hit = valid & tag match.
- PHT index = p[log2(PHT_ENTRIES)+1:2] XOR zero-extended GHR.
- Slot predicts taken if it hits and:
  - type BR and counter MSB = 1;
  - type J or CALL (target = BTB target);
  - type RET (target = RAS top if RAS count > 0, else BTB target).
- Slot 0 has priority. f1_pos = 1 if slot 0 taken. Otherwise, if slot 1 is taken, f1_pos = 0 and f1_taken = 1. Otherwise f1_taken = 0 and f1_pos = 0.

Speculative update on f1_advance & !ex_redirect:
- GHR shifts left by one if any BR hit exists in the consumed slots (slot 0, plus slot 1 unless slot 0 taken). Shifted-in bit = 1 iff the chosen prediction is a taken BR.
- CALL predicted: push (chosen slot PC + 8, delay slot). ptr+1 wraps and overwrites the oldest; count saturates at RAS_DEPTH.
- RET predicted with count > 0: pop (ptr-1, count-1). At count 0, no change.

Execute update (ex_valid), effective next cycle:
- BR: PHT[ex_pc index XOR ex_ghr] saturating ++ if taken, -- if not.
- BTB: written (valid, tag, type, target = ex_dest) when ex_taken. A not-taken BR never allocates but keeps an existing entry.
- ex_redirect:
  - GHR <= ex_type==BR ? {ex_ghr[GHR_BITS-2:0], ex_taken} : ex_ghr.
  - RAS ptr <= ex_ras_ptr, then CALL: write entry and ptr+1; RET: ptr-1.
  - Count is recomputed the same way (saturate 0..RAS_DEPTH). RAS entry contents are otherwise kept.
- Simultaneous ex_redirect and f1_advance: redirect wins; the F1 speculative update is dropped.
- Same-cycle PHT/BTB write and lookup to one index: lookup returns the old value.

Reset (async, resetn=0):
- BTB valid = 0.
- PHT counters = 2^(COUNTER_BITS-1)-1 (weakly not-taken).
- GHR = 0; RAS ptr = 0, count = 0.
- Outputs: f1_taken = 0, f1_pos = 0, f1_pre_pc = 0, f1_ghr = 0, f1_ras_ptr = 0.
- Reset mid-operation discards all state, including pending speculation.

Test Plan:
- After reset, f1_pc=0x1000 -> f1_taken=0, f1_pre_pc=0. Then three ex BR updates pc 0x1004 taken dest 0x2000 with ex_ghr=0 and GHR held 0 -> lookup 0x1000 gives f1_taken=1, f1_pos=0, f1_pre_pc=0x2000.
- CALL at 0x3000 (dest 0x5000) trained, f1_advance at 0x3000 -> f1_pre_pc=0x5000, RAS top=0x3008. RET trained at 0x5010, then lookup 0x5010 -> f1_pre_pc=0x3008, ptr returns to its original value.
- Push RAS_DEPTH+1=9 CALLs, then 9 RETs -> first 8 return in LIFO order. Ninth occurs with count 0 and uses the BTB target; the oldest address is overwritten.
- Predicted BR shifts GHR to 0x01, then ex_redirect with ex_ghr=0x00, BR, ex_taken=0 -> GHR=0x00 next cycle. The same-cycle f1_advance causes no further change.
- Counter saturation: 5 taken updates -> counter=3, then 1 not-taken -> 2, prediction still taken. Assert resetn low mid-stream -> all outputs 0 immediately.
